gate_response_checker: RTL and testbench

Self-checking response end for the basic-gate block. It drives the exhaustive A/B input sweep into a two-input gate bank, samples the seven gate outputs after a programmable settle time, and compares them against golden values. It accumulates a sticky per-gate error mask and a saturating mismatch count, then reports pass/fail. It is the synthesizable counterpart of the stimulus bench and can be used for on-board self-test of the gate bank.

---
 rtl/gate_response_checker.sv | 145 ++++++++++++++
 tb/tb_gate_response_checker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_response_checker.sv
// Self-test response checker for the two-input gate bank: sweeps {A,B}, waits for
// the outputs to settle, compares them against golden values and accumulates errors.

module gate_response_lane #(
  parameter int unsigned GATE = 0
) (
  input  logic a,
  input  logic b,
  input  logic y,
  output logic mism
);
  logic exp_bit;

  // Lane order matches the y_in bit map: and, or, not(A), nand, nor, xor, xnor.
  always_comb begin
    exp_bit = 1'b0;
    case (GATE)
      0:       exp_bit = a & b;
      1:       exp_bit = a | b;
      2:       exp_bit = ~a;
      3:       exp_bit = ~(a & b);
      4:       exp_bit = ~(a | b);
      5:       exp_bit = a ^ b;
      6:       exp_bit = ~(a ^ b);
      default: exp_bit = 1'b0;
    endcase
  end

  assign mism = y ^ exp_bit;
endmodule

module gate_response_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned PASSES        = 1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  input  logic [6:0]       y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [6:0]       err_mask,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       vec_idx
);
  localparam int unsigned NUM_GATES = 7;
  localparam int unsigned SC_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned PC_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int unsigned SUM_W = CNT_W + 3;
  localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [PC_W-1:0]  PASS_LAST   = PC_W'(PASSES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  state_t                 state;
  logic [SC_W-1:0]        settle_cnt;
  logic [PC_W-1:0]        pass_cnt;
  logic [NUM_GATES-1:0]   mism;
  logic [2:0]             pop;
  logic [SUM_W-1:0]       cnt_sum;
  logic [CNT_W-1:0]       cnt_next;
  logic                   last_vec;

  // Stimulus is the vector index itself, so {a_out,b_out} always tracks vec_idx.
  assign a_out = vec_idx[1];
  assign b_out = vec_idx[0];

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_lane
    gate_response_lane #(.GATE(g)) u_lane (
      .a    (a_out),
      .b    (b_out),
      .y    (y_in[g]),
      .mism (mism[g])
    );
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_GATES; i++) pop = pop + 3'(mism[i]);
  end

  // Wide sum so the saturation compare sees the true total before clipping.
  assign cnt_sum  = SUM_W'(err_count) + SUM_W'(pop);
  assign cnt_next = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
  assign last_vec = (vec_idx == 2'd3) && (pass_cnt == PASS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      pass_cnt   <= '0;
      vec_idx    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_mask   <= '0;
      err_count  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            err_mask   <= '0;
            err_count  <= '0;
            pass       <= 1'b0;
            vec_idx    <= '0;
            settle_cnt <= '0;
            pass_cnt   <= '0;
            busy       <= 1'b1;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) state <= S_SAMPLE;
          else                           settle_cnt <= settle_cnt + 1'b1;
        end
        S_SAMPLE: begin
          err_mask  <= err_mask | mism;
          err_count <= cnt_next;
          if (last_vec) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (cnt_next == '0);
            state <= S_DONE;
          end else begin
            if (vec_idx == 2'd3) pass_cnt <= pass_cnt + 1'b1;
            vec_idx    <= vec_idx + 1'b1;
            settle_cnt <= '0;
            state      <= S_SETTLE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker: fault-table sweeps on a default instance,
// plus saturation, abort, start-handling and settle-time corner cases.

module tb_gate_response_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, start_sat, start_s1;
  int   mode;
  logic two_stage;

  // Default instance
  logic a_out, b_out, busy, done, pass;
  logic [6:0] y_in, err_mask;
  logic [7:0] err_count;
  logic [1:0] vec_idx;

  // Saturation instance
  logic a_sat, b_sat, busy_sat, done_sat, pass_sat;
  logic [6:0] y_sat, mask_sat;
  logic [7:0] cnt_sat;
  logic [1:0] vec_sat;

  // Short-settle instance
  logic a_s1, b_s1, busy_s1, done_s1, pass_s1;
  logic [6:0] y_s1, mask_s1, r1, r2;
  logic [7:0] cnt_s1;
  logic [1:0] vec_s1;

  int checks = 0;
  int failures = 0;

  function automatic logic [6:0] golden(input logic a, input logic b);
    return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
  endfunction

  function automatic logic [6:0] faulty(input logic [6:0] g, input int m);
    logic [6:0] r;
    r = g;
    case (m)
      1: r[5] = 1'b0;
      2: r = ~g;
      3: r[0] = 1'b1;
      4: r[2] = 1'b0;
      default: r = g;
    endcase
    return r;
  endfunction

  assign y_in  = faulty(golden(a_out, b_out), mode);
  assign y_sat = ~golden(a_sat, b_sat);
  always_ff @(posedge clk) begin
    r1 <= golden(a_s1, b_s1);
    r2 <= r1;
  end
  assign y_s1 = two_stage ? r2 : r1;

  gate_response_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_out(a_out), .b_out(b_out),
    .y_in(y_in), .busy(busy), .done(done), .pass(pass), .err_mask(err_mask),
    .err_count(err_count), .vec_idx(vec_idx));

  gate_response_checker #(.PASSES(40)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start_sat), .a_out(a_sat), .b_out(b_sat),
    .y_in(y_sat), .busy(busy_sat), .done(done_sat), .pass(pass_sat), .err_mask(mask_sat),
    .err_count(cnt_sat), .vec_idx(vec_sat));

  gate_response_checker #(.SETTLE_CYCLES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_s1), .a_out(a_s1), .b_out(b_s1),
    .y_in(y_s1), .busy(busy_s1), .done(done_s1), .pass(pass_s1), .err_mask(mask_s1),
    .err_count(cnt_s1), .vec_idx(vec_s1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One-cycle start on the default instance; counts edges to done and traces the sweep.
  task automatic run_dflt(output int lat, output logic seq_ok, output logic busy_ok);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 0; seq_ok = 1'b1; busy_ok = 1'b1;
    while (!done && lat < 200) begin
      if ({a_out, b_out} != 2'(lat / 3) || vec_idx != 2'(lat / 3)) seq_ok = 1'b0;
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    string      name;
    int         mode;
    logic [6:0] mask;
    logic [7:0] cnt;
    logic       pass;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int lat, k, nd, d1, d2, wait_cnt;
    logic seq_ok, busy_ok, idle_gap;
    logic [14:0] cleared;
    logic [14:0] held;

    tbl[0] = '{"good",      0, 7'h00, 8'd0,  1'b1};
    tbl[1] = '{"xor_sa0",   1, 7'h20, 8'd2,  1'b0};
    tbl[2] = '{"inverted",  2, 7'h7F, 8'd28, 1'b0};
    tbl[3] = '{"and_sa1",   3, 7'h01, 8'd3,  1'b0};
    tbl[4] = '{"not_sa0",   4, 7'h04, 8'd2,  1'b0};

    rst_n = 1'b0; start = 1'b0; start_sat = 1'b0; start_s1 = 1'b0;
    mode = 0; two_stage = 1'b0;
    #12;
    chk("reset_state", {a_out, b_out, busy, done, pass, err_mask, err_count, vec_idx}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Fault table on the default instance
    for (int i = 0; i < 5; i++) begin
      mode = tbl[i].mode;
      run_dflt(lat, seq_ok, busy_ok);
      chk({tbl[i].name, "_latency"}, lat, 12);
      chk({tbl[i].name, "_vec_seq"}, seq_ok, 1'b1);
      chk({tbl[i].name, "_busy_run"}, busy_ok, 1'b1);
      chk({tbl[i].name, "_done_busy"}, {busy, {a_out, b_out}}, {1'b0, 2'b11});
      chk({tbl[i].name, "_mask"}, err_mask, tbl[i].mask);
      chk({tbl[i].name, "_count"}, err_count, tbl[i].cnt);
      chk({tbl[i].name, "_pass"}, pass, tbl[i].pass);
      held = {err_mask, err_count};
      @(negedge clk);
      chk({tbl[i].name, "_done_pulse"}, done, 1'b0);
      repeat (3) @(negedge clk);
      chk({tbl[i].name, "_retained"}, {pass, err_mask, err_count}, {tbl[i].pass, held});
    end

    // Async abort at vec_idx==2: outputs clear before any edge, no done follows
    mode = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_cnt = 0;
    while (vec_idx != 2'd2 && wait_cnt < 50) begin @(negedge clk); wait_cnt++; end
    chk("abort_reach_vec2", vec_idx, 2'd2);
    #2 rst_n = 1'b0;
    #1 chk("abort_clear", {a_out, b_out, busy, done, pass, err_mask, err_count, vec_idx}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 30; c++) begin @(negedge clk); if (done) nd++; end
    chk("abort_no_done", nd, 0);
    run_dflt(lat, seq_ok, busy_ok);
    chk("rerun_latency", lat, 12);
    chk("rerun_result", {pass, err_mask, err_count}, {1'b1, 7'h00, 8'd0});

    // Extra start pulses while busy are ignored
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      start = (c == 3 || c == 7);
      @(negedge clk);
      if (done) nd++;
    end
    start = 1'b0;
    chk("busy_start_one_done", nd, 1);

    // Start held high: back-to-back runs, one idle cycle apart, results cleared each start
    mode = 1;
    repeat (3) @(negedge clk);
    start = 1'b1;
    d1 = -1; d2 = -1; idle_gap = 1'b1; cleared = '1;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        if (d1 < 0) begin
          d1 = k;
          chk("held_run1_count", err_count, 8'd2);
        end else if (d2 < 0) d2 = k;
      end
      if (d1 >= 0 && k == d1 + 1) idle_gap = busy | done;
      if (d1 >= 0 && k == d1 + 2) cleared = {err_mask, err_count};
    end
    start = 1'b0;
    chk("held_first_done", d1, 13);
    chk("held_done_spacing", d2 - d1, 14);
    chk("held_idle_gap", idle_gap, 1'b0);
    chk("held_clear_on_start", cleared, 15'd0);
    wait_cnt = 0;
    while (busy && wait_cnt < 50) begin @(negedge clk); wait_cnt++; end
    chk("held_drain", busy, 1'b0);
    repeat (2) @(negedge clk);

    // Saturation: 1120 raw mismatches clipped at 255
    @(negedge clk); start_sat = 1'b1;
    @(negedge clk); start_sat = 1'b0;
    lat = 0;
    while (!done_sat && lat < 1000) begin @(negedge clk); lat++; end
    chk("sat_latency", lat, 480);
    chk("sat_count", cnt_sat, 8'd255);
    chk("sat_mask", mask_sat, 7'h7F);
    chk("sat_pass", pass_sat, 1'b0);

    // One-cycle settle: one register stage fits, two do not
    for (int s = 0; s < 2; s++) begin
      two_stage = (s == 1);
      @(negedge clk); start_s1 = 1'b1;
      @(negedge clk); start_s1 = 1'b0;
      lat = 0;
      while (!done_s1 && lat < 100) begin @(negedge clk); lat++; end
      chk(s == 0 ? "s1_one_stage_latency" : "s1_two_stage_latency", lat, 8);
      if (s == 0) begin
        chk("s1_one_stage_pass", pass_s1, 1'b1);
        chk("s1_one_stage_mask", mask_s1, 7'h00);
      end else begin
        chk("s1_two_stage_pass", pass_s1, 1'b0);
        chk("s1_two_stage_mask_nonzero", mask_s1 != 7'h00, 1'b1);
      end
      repeat (2) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
